// File: rtl/spi_target_rx.sv
// Receive-only SPI mode-3 target: synchronizes nCS/SCLK/SDI into clk, deserializes
// MSB-first bytes on SCLK rising edges and queues them in a small valid/ready FIFO.
module spi_target_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nCS,
  input  logic       SCLK,
  input  logic       SDI,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overflow,
  output logic       frame_err,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  // cs resets to "selected" so a frame already running at reset release is skipped
  logic [SYNC_STAGES-1:0] cs_q, sclk_q, sdi_q;
  logic                   sclk_d;
  logic                   cs_s, sclk_s, sdi_s, rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q   <= '0;
      sclk_q <= '1;
      sdi_q  <= '0;
      sclk_d <= 1'b1;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0], nCS};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      sdi_q  <= {sdi_q[SYNC_STAGES-2:0], SDI};
      sclk_d <= sclk_s;
    end
  end

  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;

  state_t     state;
  logic [2:0] bitcnt;
  logic [7:0] sr;
  logic       push;
  logic [7:0] push_byte;

  assign push      = (state == SHIFT) && !cs_s && rise && (bitcnt == 3'd7);
  assign push_byte = {sr[6:0], sdi_s};
  assign busy      = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_IDLE;
      bitcnt    <= '0;
      sr        <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        WAIT_IDLE: if (cs_s) state <= IDLE;
        IDLE: if (!cs_s) begin
          state  <= SHIFT;
          bitcnt <= '0;
        end
        SHIFT: begin
          // deselect wins over a coincident rise
          if (cs_s) begin
            state     <= IDLE;
            frame_err <= (bitcnt != 3'd0);
            bitcnt    <= '0;
          end else if (rise) begin
            sr     <= push_byte;
            bitcnt <= bitcnt + 3'd1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop;

  assign rx_valid = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rx_valid & rx_ready;
  assign rx_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      // a pop in the same cycle frees the head slot, so a full FIFO still accepts
      if (push) begin
        if (!full || pop) begin
          mem[wr_ptr[AW-1:0]] <= push_byte;
          wr_ptr              <= wr_ptr + PTR_ONE;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule
